// File: rtl/fitbit_display.sv
// fitbit_display: seven-segment front end for the fitbit metrics.
//
// Shows one of four 16-bit metrics at a time, rotating every ROTATE_CYCLES clocks
// unless hold is set. The shown metric is saturated at 9999, converted to BCD by a
// sequential double-dabble and scanned across four active-low common-anode digits.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   step_count   total steps (binary)
//   distance     distance in tenths of a mile (binary)
//   fast_secs    seconds over 32 steps/s
//   active_secs  high-activity seconds
//   hold         1 = freeze metric rotation
//   sel          index of the metric shown (0..3)
//   an           digit anodes, active-low one-hot, an[0] = rightmost digit
//   seg          {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low (lit on digit 1 while distance is shown)
//   SI           sticky step-overflow indicator
//
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is
// never blanked; digit 1 is never blanked while distance is shown).

module fitbit_display #(
    parameter int unsigned ROTATE_CYCLES  = 200000000,
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] step_count,
    input  logic [15:0] distance,
    input  logic [15:0] fast_secs,
    input  logic [15:0] active_secs,
    input  logic        hold,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        SI
);

    localparam int unsigned RotW = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
    localparam int unsigned RefW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [15:0] MaxVal = 16'd9999;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} convState_e;

    logic [RotW-1:0] rotCnt;
    logic [RefW-1:0] scanCnt;
    logic [1:0]      scanIdx;
    convState_e      convState, convNext;
    logic [31:0]     shiftReg;     // {bcd[15:0], binary[15:0]}
    logic [31:0]     dabbled;
    logic [3:0]      shiftCnt;
    logic [1:0]      loadSel;      // metric index captured by the running conversion
    logic [15:0]     dispBcd;
    logic [15:0]     metric, metricSat;
    logic [3:0]      digit;
    logic [6:0]      segNext;
    logic [3:0]      anNext;

    // Metric rotation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rotCnt <= '0;
            sel    <= 2'd0;
        end else if (!hold) begin
            if (rotCnt == RotW'(ROTATE_CYCLES - 1)) begin
                rotCnt <= '0;
                sel    <= sel + 2'd1;
            end else begin
                rotCnt <= rotCnt + RotW'(1);
            end
        end
    end

    always_comb begin
        metric = step_count;
        case (sel)
            2'd0:    metric = step_count;
            2'd1:    metric = distance;
            2'd2:    metric = fast_secs;
            default: metric = active_secs;
        endcase
        metricSat = (metric > MaxVal) ? MaxVal : metric;
    end

    // One double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
    always_comb begin
        dabbled = shiftReg;
        for (int i = 0; i < 4; i++) begin
            if (dabbled[16+4*i +: 4] >= 4'd5) begin
                dabbled[16+4*i +: 4] = dabbled[16+4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            convState <= StIdle;
        end else begin
            convState <= convNext;
        end
    end

    always_comb begin
        convNext = convState;
        case (convState)
            StIdle:   convNext = StLoad;
            StLoad:   convNext = StShift;
            StShift: begin
                // A rotation mid-conversion restarts on the new metric
                if (sel != loadSel) begin
                    convNext = StLoad;
                end else if (shiftCnt == 4'd15) begin
                    convNext = StCommit;
                end
            end
            StCommit: convNext = StLoad;
            default:  convNext = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shiftReg <= '0;
            shiftCnt <= '0;
            loadSel  <= 2'd0;
            dispBcd  <= '0;
        end else begin
            case (convState)
                StLoad: begin
                    shiftReg <= {16'd0, metricSat};
                    shiftCnt <= '0;
                    loadSel  <= sel;
                end
                StShift: begin
                    shiftReg <= {dabbled[30:0], 1'b0};
                    shiftCnt <= shiftCnt + 4'd1;
                end
                StCommit: dispBcd <= shiftReg[31:16];
                default: ;
            endcase
        end
    end

    // Digit scan
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scanCnt <= '0;
            scanIdx <= 2'd0;
        end else if (scanCnt == RefW'(REFRESH_CYCLES - 1)) begin
            scanCnt <= '0;
            scanIdx <= scanIdx + 2'd1;
        end else begin
            scanCnt <= scanCnt + RefW'(1);
        end
    end

    always_comb begin
        digit = dispBcd[3:0];
        case (scanIdx)
            2'd0:    digit = dispBcd[3:0];
            2'd1:    digit = dispBcd[7:4];
            2'd2:    digit = dispBcd[11:8];
            default: digit = dispBcd[15:12];
        endcase
        segNext = 7'h7F;
        case (digit)
            4'd0:    segNext = 7'h40;
            4'd1:    segNext = 7'h79;
            4'd2:    segNext = 7'h24;
            4'd3:    segNext = 7'h30;
            4'd4:    segNext = 7'h19;
            4'd5:    segNext = 7'h12;
            4'd6:    segNext = 7'h02;
            4'd7:    segNext = 7'h78;
            4'd8:    segNext = 7'h00;
            4'd9:    segNext = 7'h10;
            default: segNext = 7'h7F;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] leadZero;  // leadZero[k]: nibbles k..3 are all zero

    always_comb begin
        leadZero[3] = (dispBcd[15:12] == 4'd0);
        leadZero[2] = leadZero[3] && (dispBcd[11:8] == 4'd0);
        leadZero[1] = leadZero[2] && (dispBcd[7:4] == 4'd0);
        leadZero[0] = 1'b0;
        anNext = ~(4'b0001 << scanIdx);
        if (leadZero[scanIdx] && !(sel == 2'd1 && scanIdx == 2'd1)) begin
            anNext = 4'b1111;
        end
    end
`else
    always_comb begin
        anNext = ~(4'b0001 << scanIdx);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
            SI  <= 1'b0;
        end else begin
            an  <= anNext;
            seg <= segNext;
            dp  <= !(sel == 2'd1 && scanIdx == 2'd1);
            SI  <= SI | (step_count > MaxVal);
        end
    end

endmodule

// File: tb/tb_fitbit_display.sv
// Scoreboard bench for fitbit_display: a per-edge reference model pushes the expected
// outputs, and a monitor on the falling edge pops and compares them.

module tb_fitbit_display;

    localparam int unsigned ROT = 40;
    localparam int unsigned REF = 4;

    logic        clk;
    logic        reset;
    logic [15:0] step_count, distance, fast_secs, active_secs;
    logic        hold;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, SI;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       segValid;
        logic       dp;
        logic [1:0] sel;
        logic       si;
    } expRec_t;

    expRec_t expQ[$];
    int unsigned nCompared;
    int unsigned nMismatched;

    fitbit_display #(
        .ROTATE_CYCLES (ROT),
        .REFRESH_CYCLES(REF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_count (step_count),
        .distance   (distance),
        .fast_secs  (fast_secs),
        .active_secs(active_secs),
        .hold       (hold),
        .sel        (sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .SI         (SI)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input int unsigned d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Decimal digit 'pos' of the value as the display should show it (capped at 9999)
    function automatic int unsigned digitOf(input logic [15:0] v, input int unsigned pos);
        int unsigned sat;
        sat = (v > 16'd9999) ? 9999 : int'(v);
        return (sat / (10 ** pos)) % 10;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what every output must be after each rising edge
    initial begin
        int unsigned n, active, sinceSel, sinceData, sinceSelPrev;
        int unsigned selB, idxB, selA;
        logic        siM;
        logic [15:0] snap [4];
        expRec_t     e;
        n = 0; active = 0; sinceSel = 0; sinceData = 1000; siM = 1'b0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                n = 0; active = 0; siM = 1'b0;
                sinceSel = 0;      // release acts like a fresh metric selection
                sinceData = 1000;
                snap[0] = step_count; snap[1] = distance;
                snap[2] = fast_secs;  snap[3] = active_secs;
                e.an = 4'hF; e.seg = 7'h7F; e.segValid = 1'b1; e.dp = 1'b1;
                e.sel = 2'd0; e.si = 1'b0;
            end else begin
                selB = (active / ROT) % 4;
                idxB = (n / REF) % 4;
                sinceSelPrev = sinceSel;
                n++;
                if (!hold) active++;
                selA = (active / ROT) % 4;
                if (step_count > 16'd9999) siM = 1'b1;
                if (step_count != snap[0] || distance != snap[1] ||
                    fast_secs != snap[2] || active_secs != snap[3]) begin
                    sinceData = 0;
                    snap[0] = step_count; snap[1] = distance;
                    snap[2] = fast_secs;  snap[3] = active_secs;
                end else if (sinceData < 1000) begin
                    sinceData++;
                end
                if (selA != selB) sinceSel = 0;
                else if (sinceSel < 1000) sinceSel++;
                e.an  = 4'(~(4'b0001 << idxB));
                e.sel = 2'(selA);
                e.si  = siM;
                e.dp  = !(selB == 1 && idxB == 1);
                // Digits are only defined once a full conversion of the current
                // metric has been committed (conversion latency plus scan register)
                e.segValid = (sinceSelPrev >= 20) && (sinceData >= 37);
                e.seg = segOf(digitOf(snap[selB], idxB));
            end
            expQ.push_back(e);
        end
    end

    // Monitor
    initial begin
        expRec_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL scoreboard: got empty queue, expected a record at t=%0t", $time);
            end else begin
                e = expQ.pop_front();
                if (!reset) begin
                    check("reset_an", an, 4'hF);
                    check("reset_seg", seg, 7'h7F);
                    check("reset_dp", dp, 1);
                    check("reset_SI", SI, 0);
                    check("reset_sel", sel, 0);
                end else begin
                    check("an", an, e.an);
                    check("dp", dp, e.dp);
                    check("sel", sel, e.sel);
                    check("SI", SI, e.si);
                    if (e.segValid) check("seg", seg, e.seg);
                end
            end
        end
    end

    task automatic cycles(input int unsigned k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] randVal();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(10000, 65535));
        return 16'($urandom_range(0, 9999));
    endfunction

    initial begin
        nCompared = 0;
        nMismatched = 0;
        reset = 1'b0;
        step_count = 16'd1234; distance = 16'd57; fast_secs = 16'd300; active_secs = 16'd42;
        hold = 1'b0;
        cycles(5);
        reset = 1'b1;
        cycles(200);                   // full rotation including 3 -> 0 wrap
        step_count = 16'd9999; hold = 1'b1;
        cycles(3 * ROT);
        hold = 1'b0;
        cycles(80);
        step_count = 16'd12000;
        cycles(160);
        step_count = 16'd50;           // SI must stay set
        cycles(80);
        fast_secs = 16'd0; active_secs = 16'd0;
        cycles(160);
        cycles(7);
        reset = 1'b0;                  // reset while a conversion is in flight
        cycles(3);
        reset = 1'b1;
        step_count = 16'd0;
        cycles(160);
        for (int p = 0; p < 40; p++) begin
            step_count  = randVal();
            distance    = randVal();
            fast_secs   = randVal();
            active_secs = randVal();
            hold        = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b0;
                cycles($urandom_range(1, 4));
                reset = 1'b1;
            end
            cycles($urandom_range(40, 160));
        end
        hold = 1'b0;
        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
